// File: rtl/execute_stage.sv
// execute_stage: MIPS EX stage with operand forwarding, a single-cycle ALU
// and a 32-step shift-add multiplier that stalls the front end via exHOLD.
module execute_stage #(
   parameter int MUL_ITER = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [135:0] IDEXReg,
   input  logic [70:0]  MEMWBReg,
   output logic [74:0]  EXMEReg,
   output logic         exHOLD
);
   localparam int CW = $clog2(MUL_ITER);
   localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2;

   logic        regDst, memRead, memtoReg, memWrite, aluSrc, regWrite, isMul;
   logic [1:0]  aluOp, state;
   logic [4:0]  rs, rt, rd, shamt, wReg;
   logic [5:0]  funct;
   logic [31:0] ext, rd1, rd2, wbVal, a, bFwd, b, aluOut, acc, mcand, mplier;
   logic [CW-1:0] cnt;

   assign {regDst, memRead, memtoReg, aluOp, memWrite, aluSrc, regWrite} = IDEXReg[135:128];
   assign ext   = IDEXReg[127:96];
   assign rd2   = IDEXReg[95:64];
   assign rd1   = IDEXReg[63:32];
   assign rs    = IDEXReg[25:21];
   assign rt    = IDEXReg[20:16];
   assign rd    = IDEXReg[15:11];
   assign shamt = IDEXReg[10:6];
   assign funct = IDEXReg[5:0];
   assign isMul = aluOp == 2'b10 && funct == 6'h18;
   assign wReg  = regDst ? rd : rt;
   assign wbVal = MEMWBReg[70] ? MEMWBReg[31:0] : MEMWBReg[69:38];

   // EX/MEM wins over MEM/WB; $0 is never forwarded
   function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] dflt);
      return (EXMEReg[69] && EXMEReg[68:64] != 5'd0 && EXMEReg[68:64] == r) ? EXMEReg[31:0]
           : (MEMWBReg[37] && MEMWBReg[36:32] != 5'd0 && MEMWBReg[36:32] == r) ? wbVal : dflt;
   endfunction

   assign a    = fwd(rs, rd1);
   assign bFwd = fwd(rt, rd2);
   assign b    = aluSrc ? ext : bFwd;

   always_comb begin
      aluOut = '0;
      case (aluOp)
         2'b00: aluOut = a + b;
         2'b01: aluOut = a - b;
         2'b11: aluOut = a | b;
         default:
            case (funct)
               6'h20: aluOut = a + b;
               6'h22: aluOut = a - b;
               6'h24: aluOut = a & b;
               6'h25: aluOut = a | b;
               6'h2A: aluOut = {31'd0, $signed(a) < $signed(b)};
               6'h00: aluOut = bFwd << shamt;
               default: aluOut = '0;
            endcase
      endcase
   end

   function automatic logic [74:0] word(input logic [31:0] res);
      return {res == 32'd0, 1'b1, memRead, memWrite, memtoReg, regWrite, wReg, bFwd, res};
   endfunction

   // low 32 bits of the product are sign-agnostic, so an unsigned shift-add suffices
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         EXMEReg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (isMul) begin
                  mcand   <= a;
                  mplier  <= bFwd;
                  acc     <= '0;
                  cnt     <= '0;
                  EXMEReg <= '0;
                  state   <= MUL;
               end else EXMEReg <= word(aluOut);
            end
            MUL: begin
               acc     <= mplier[0] ? acc + mcand : acc;
               mcand   <= mcand << 1;
               mplier  <= mplier >> 1;
               cnt     <= cnt + 1'b1;
               EXMEReg <= '0;
               if (cnt == CW'(MUL_ITER - 1)) state <= DONE;
            end
            DONE: begin
               EXMEReg <= word(acc);
               state   <= IDLE;
            end
            default: begin
               EXMEReg <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign exHOLD = !rst && ((state == IDLE && isMul) || state == MUL);
endmodule

// File: doc/execute_stage.md
# execute_stage

Pipeline EX stage of the 5-stage MIPS core. It consumes the 136-bit ID/EX register produced by decode and registers the 75-bit EX/MEM word that the memory stage reads and that decode forwards from. It resolves operand forwarding from EX/MEM and MEM/WB and runs the single-cycle ALU. A 32-cycle iterative multiplier stalls the front end through `exHOLD`.

## Interface
- `MUL_ITER`, 32: multiplier iterations, one product bit per cycle; fixed at 32 for 32-bit operands.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `IDEXReg` in 136: {ctrl[135:128], ext[127:96], rd2[95:64], rd1[63:32], instr[31:0]}.
  - ctrl bits: 135 RegDst, 134 MemRead, 133 MemtoReg, 132:131 ALUOp, 130 MemWrite, 129 ALUSrc, 128 RegWrite.
- `MEMWBReg` in 71: 70 MemtoReg, 69:38 ALU result, 37 RegWrite, 36:32 write reg, 31:0 read data.
- `EXMEReg` out 75, registered:
  - 31:0 ALU result, 63:32 store data, 68:64 write reg.
  - 69 RegWrite, 70 MemtoReg, 71 MemWrite, 72 MemRead.
  - 73 Valid, 74 Zero.
- `exHOLD` out 1: combinational stall request. While high, PC, IF/ID and ID/EX hold their contents.

## Operation
- Decode from `instr`:
  - rs = [25:21], rt = [20:16], rd = [15:11], shamt = [10:6], funct = [5:0].
- Forwarding, per operand, priority order:
  1. EX/MEM: `EXMEReg[69]`=1, `EXMEReg[68:64]`≠0 and equal to rs (rt) → use `EXMEReg[31:0]`.
  2. MEM/WB: `MEMWBReg[37]`=1, `MEMWBReg[36:32]`≠0 and equal → use `MEMWBReg[70]` ? `MEMWBReg[31:0]` : `MEMWBReg[69:38]`.
  3. Otherwise use rd1 (rd2).
  - Results: A = forwarded rs value; Bfwd = forwarded rt value; B = ALUSrc ? ext : Bfwd.
- ALU, all results 32-bit with wrap-around:
  - ALUOp 00 → A+B.
  - ALUOp 01 → A−B.
  - ALUOp 11 → A|B.
  - ALUOp 10 → by funct:
    - 0x20 add, 0x22 sub, 0x24 and, 0x25 or.
    - 0x2A slt: signed, result 1 or 0.
    - 0x00 sll: Bfwd << shamt.
    - 0x18 mul: low 32 bits of the signed product, multi-cycle.
    - Any other funct → result 0.
- Write reg = RegDst ? rd : rt. Store data = Bfwd. Zero = (result==0).
- Control bits in `EXMEReg[72:69]` are copied from ctrl.
- Bubble word: all 75 bits 0 (Valid=0, RegWrite=0, MemWrite=0).
- Multiplier FSM:
  - States: IDLE, MUL, DONE.
  - IDLE, `isMul` (ALUOp=10, funct=0x18):
    - At the edge, latch A and Bfwd; counter ← 0; go to MUL.
    - `EXMEReg` ← bubble.
  - MUL:
    - One shift-add step per edge; counter increments.
    - After step 32 (counter = 31 → wraps), go to DONE.
    - `EXMEReg` ← bubble on every edge.
  - DONE:
    - At the edge, `EXMEReg` ← product word (Valid=1, control from the held `IDEXReg`); go to IDLE.
  - IDLE, non-mul: `EXMEReg` ← normal ALU word on every edge.
- `exHOLD` = (IDLE && `isMul`) || MUL. It is 0 in DONE, so the front end advances at the same edge the product is registered.
- Back-to-back mul: after DONE the FSM is IDLE and starts the next mul immediately; no extra gap.
- Multiply operands are taken from the latched values, never re-forwarded during MUL.

## Timing
- Reset, asynchronous:
  - `EXMEReg` = 0, FSM = IDLE, counter = 0.
  - `exHOLD` = 0 while `rst` is high.
- Reset mid-multiply aborts the operation; no result is emitted.
- Non-mul latency: `IDEXReg` presented in cycle n → `EXMEReg` valid after edge n+1.
- Mul latency:
  - Present in cycle n → bubbles registered at edges n+1 … n+33.
  - Product registered at edge n+34.
  - `exHOLD` high for cycles n … n+32 (33 cycles).
- Forwarding is purely combinational: the value visible on `EXMEReg` and `MEMWBReg` in the same cycle is used.

## Test plan
- Reset: assert `rst` mid-run → `EXMEReg`=0 and `exHOLD`=0 immediately, before any clock edge.
- add $3,$1,$2 (rd1=5, rd2=7), no forwarding → `EXMEReg[31:0]`=12, `[68:64]`=3, Valid=1, Zero=0.
- Forwarding priority:
  - `EXMEReg` writes $1=100 and `MEMWBReg` writes $1=200 → sub $4,$1,$0 yields 100.
  - With only `MEMWBReg` (MemtoReg=1, read data 0x55) matching → yields 0x55.
  - A write to $0 is never forwarded.
- lw with rs value 0x1000, imm 0xFFFC (ext 0xFFFFFFFC), ALUOp=00, ALUSrc=1 → address 0x0FFC, MemRead=1, write reg = rt.
- mul $5,$6,$7 with 7 and −3 → `exHOLD` high for exactly 33 cycles, 33 bubble words, then result 0xFFFFFFEB with `[68:64]`=5.
  - Back-to-back second mul: its product lands 34 edges later.
- slt signed: −1 vs 1 → 1. `rst` pulse during MUL iteration 10 → IDLE, no product word, `exHOLD` low after reset.
